mem_responder: RTL and testbench
================================

# mem_responder

Word-organised on-chip memory that acts as the responder end of the core's req/gnt/rvalid memory handshake. It sits behind the fetch or load/store unit and accepts one request per grant. It performs byte-enabled writes and reads, and returns in-order responses after a fixed latency. An optional grant-throttle counter models a slow memory so that requester stall paths can be exercised.

## Interface
- ADDR_WIDTH, 32, width of i_data_addr.
- DEPTH_WORDS, 1024, number of 32-bit words.
- BASE_ADDR, 32'h0, byte address mapped to word 0.
- LATENCY, 1, cycles from the grant edge to the rvalid cycle; legal range is at least 1.
- GNT_STALL, 0, number of cycles o_data_gnt is forced low after each grant.
- INIT_FILE, "", hex image loaded with $readmemh at elaboration when the string is non-empty.
- i_clk  in  1  clock.
- i_resetn  in  1  reset, asynchronous, active-low.
- i_data_req  in  1  request valid.
- o_data_gnt  out  1  request accepted this cycle.
- i_data_addr  in  ADDR_WIDTH  byte address.
- i_data_we  in  1  1 = write, 0 = read.
- i_data_be  in  4  byte enables; bit n selects byte lane n.
- i_data_wdata  in  32  write data.
- o_data_rvalid  out  1  response valid, one cycle per accepted request.
- o_data_rdata  out  32  read data.
- o_data_err  out  1  error response, qualified by rvalid.

## Operation
- Grant logic:
  - o_data_gnt = i_data_req & i_resetn & (stall_cnt == 0). The path is combinational from req.
  - A request is accepted at a rising edge when req and gnt are both high.
  - The requester must hold addr, we, be and wdata stable while req is high and gnt is low.
- Throttle counter stall_cnt:
  - Reset value 0.
  - Loaded with GNT_STALL on each accept.
  - Decrements by 1 per cycle while nonzero.
  - With GNT_STALL = 0, one accept per cycle is allowed.
- Address decode at accept:
  - off = addr − BASE_ADDR, computed ADDR_WIDTH wide.
  - Error if addr < BASE_ADDR, or off[1:0] ≠ 0, or off[ADDR_WIDTH−1:2] ≥ DEPTH_WORDS.
- Write, no error:
  - Each byte lane with be[n] = 1 is written at the accept edge.
  - Other lanes are unchanged.
  - The response carries rdata = 0 and err = 0.
- Read, no error:
  - The word is sampled at the accept edge, so it reflects all earlier accepted writes.
  - be is ignored for reads; the full word is returned.
- Error:
  - No memory update.
  - The response carries err = 1 and rdata = 0.
- Every accepted request, read or write, produces exactly one response.
- Response pipeline:
  - A shift register of LATENCY stages; each stage holds {valid, err, data}.
  - Stage 0 is loaded on accept; otherwise stage 0 is loaded with valid = 0.
  - The pipeline advances every cycle with no backpressure: the requester must always accept rvalid.
  - Responses leave in acceptance order.
- o_data_rvalid and o_data_err come from the last stage. o_data_err is 0 whenever rvalid is 0.
- o_data_rdata is updated only when a valid response leaves the pipeline, and holds its last value otherwise.
- Memory array: not reset. Contents come from INIT_FILE or are X.

## Timing
- Reset (async assert):
  - o_data_gnt = 0, o_data_rvalid = 0, o_data_err = 0, o_data_rdata = 0, stall_cnt = 0.
  - All pipeline valid bits are cleared.
- Reset asserted mid-operation: in-flight responses are dropped and never delivered. Writes already accepted remain in memory.
- Response timing: for an accept at edge k, o_data_rvalid is high during the cycle after edge k+LATENCY−1.
  - With LATENCY = 1, rvalid is high in the cycle immediately after the grant cycle.
- Throughput: one response per cycle when GNT_STALL = 0; one per GNT_STALL+1 cycles otherwise.
- Simultaneous events:
  - A new accept and a response leaving in the same cycle are independent.
  - A read and a write to the same word in consecutive accepts: the later read returns the new data.
- Deassertion of req without a grant is legal. No response is generated for it.

## Test plan
- Reset, then hold req = 0 for 5 cycles:
  - gnt, rvalid and err stay 0.
  - rdata stays 32'h0.
- LATENCY = 1, GNT_STALL = 0:
  - Write 32'hDEADBEEF with be = 4'hF to BASE_ADDR+8, then read the same address back-to-back.
  - Two consecutive gnt cycles.
  - Write response: rvalid, err = 0.
  - Next cycle, read response: rdata = 32'hDEADBEEF.
- Partial write:
  - Write 32'h11223344 with be = 4'b0101 over a word holding 32'hAAAAAAAA, then read.
  - rdata = 32'hAA22AA44.
- Errors:
  - Read BASE_ADDR+2 → err = 1, rdata = 0.
  - Read BASE_ADDR+4*DEPTH_WORDS → err = 1.
  - Write to an illegal address, then read the neighbouring words → contents unchanged.
- LATENCY = 3, GNT_STALL = 2, req held high for 12 cycles:
  - gnt pulses every 3rd cycle.
  - Each rvalid appears exactly 3 cycles after its gnt edge.
  - Responses arrive in order.
- Reset pulse asserted while 2 responses are in flight (LATENCY = 3):
  - Neither response is delivered after reset release.
  - A subsequent read returns the data written before reset.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Byte-enabled word memory answering req/gnt/rvalid requests with
//            in-order responses after a fixed latency, plus optional grant throttle.
// Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    LATENCY     = 1,
    parameter int                    GNT_STALL   = 0,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_data_req,
    output logic                  o_data_gnt,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    input  logic                  i_data_we,
    input  logic [3:0]            i_data_be,
    input  logic [31:0]           i_data_wdata,
    output logic                  o_data_rvalid,
    output logic [31:0]           o_data_rdata,
    output logic                  o_data_err
);
    localparam int c_IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_STALL_W = $clog2(GNT_STALL + 2);
    localparam int c_WOFF_W  = ADDR_WIDTH - 2;
    localparam logic [c_STALL_W-1:0] c_STALL = c_STALL_W'(GNT_STALL);
    localparam logic [c_WOFF_W-1:0]  c_DEPTH = c_WOFF_W'(DEPTH_WORDS);

    logic [ADDR_WIDTH-1:0] w_off;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_err;
    logic                  w_accept;
    logic [31:0]           w_resp_data;

    logic [c_STALL_W-1:0]  r_stall_cnt;
    logic [31:0]           r_mem [DEPTH_WORDS];
    logic [LATENCY-1:0]    r_pv;
    logic [LATENCY-1:0]    r_pe;
    logic [31:0]           r_pd [LATENCY];
    logic [31:0]           r_rdata_hold;

    assign o_data_gnt = i_data_req & i_resetn & (r_stall_cnt == '0);
    assign w_accept   = i_data_req & o_data_gnt;

    // The offset subtraction wraps for addresses below the base, so that case is tested directly.
    assign w_off = i_data_addr - BASE_ADDR;
    assign w_err = (i_data_addr < BASE_ADDR) || (w_off[1:0] != 2'b00) ||
                   (w_off[ADDR_WIDTH-1:2] >= c_DEPTH);
    assign w_idx = w_off[c_IDX_W+1:2];

    assign w_resp_data = (i_data_we || w_err) ? 32'h0 : r_mem[w_idx];

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= c_STALL;
        end else if (r_stall_cnt != '0) begin
            r_stall_cnt <= r_stall_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept && i_data_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (i_data_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_data_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_pv <= '0;
            r_pe <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pd[i] <= 32'h0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pe[0] <= w_accept & w_err;
            r_pd[0] <= w_accept ? w_resp_data : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    // Read data is presented with rvalid and held afterwards until the next response.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rdata_hold <= 32'h0;
        end else if (r_pv[LATENCY-1]) begin
            r_rdata_hold <= r_pd[LATENCY-1];
        end
    end

    assign o_data_rvalid = r_pv[LATENCY-1];
    assign o_data_err    = r_pv[LATENCY-1] & r_pe[LATENCY-1];
    assign o_data_rdata  = r_pv[LATENCY-1] ? r_pd[LATENCY-1] : r_rdata_hold;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Randomised and directed bench for mem_responder on three configs.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;
    localparam int          N_DUT = 3;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE0 = 32'h0000_0100;
    localparam logic [31:0] BASE1 = 32'h0000_0000;
    localparam logic [31:0] BASE2 = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req    [N_DUT];
    logic [31:0] addr   [N_DUT];
    logic        we     [N_DUT];
    logic [3:0]  be     [N_DUT];
    logic [31:0] wdata  [N_DUT];
    logic        gnt    [N_DUT];
    logic        rvalid [N_DUT];
    logic [31:0] rdata  [N_DUT];
    logic        err    [N_DUT];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0),
                    .LATENCY(1), .GNT_STALL(0), .INIT_FILE("")) u_dut0 (
        .i_clk(clk), .i_resetn(resetn), .i_data_req(req[0]), .o_data_gnt(gnt[0]),
        .i_data_addr(addr[0]), .i_data_we(we[0]), .i_data_be(be[0]), .i_data_wdata(wdata[0]),
        .o_data_rvalid(rvalid[0]), .o_data_rdata(rdata[0]), .o_data_err(err[0]));

    mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1),
                    .LATENCY(3), .GNT_STALL(2), .INIT_FILE("")) u_dut1 (
        .i_clk(clk), .i_resetn(resetn), .i_data_req(req[1]), .o_data_gnt(gnt[1]),
        .i_data_addr(addr[1]), .i_data_we(we[1]), .i_data_be(be[1]), .i_data_wdata(wdata[1]),
        .o_data_rvalid(rvalid[1]), .o_data_rdata(rdata[1]), .o_data_err(err[1]));

    mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE2),
                    .LATENCY(3), .GNT_STALL(0), .INIT_FILE("")) u_dut2 (
        .i_clk(clk), .i_resetn(resetn), .i_data_req(req[2]), .o_data_gnt(gnt[2]),
        .i_data_addr(addr[2]), .i_data_we(we[2]), .i_data_be(be[2]), .i_data_wdata(wdata[2]),
        .o_data_rvalid(rvalid[2]), .o_data_rdata(rdata[2]), .o_data_err(err[2]));

    // Reference state: word image per instance, and responses keyed by the edge they are due.
    logic [31:0] mmem     [N_DUT][DEPTH];
    int unsigned ecnt = 0;
    int unsigned rst_gen = 0;
    int unsigned next_ok  [N_DUT] = '{0, 0, 0};
    bit          last_acc [N_DUT];
    bit          slot_set [N_DUT][8];
    int unsigned slot_due [N_DUT][8];
    int unsigned slot_gen [N_DUT][8];
    bit          slot_e   [N_DUT][8];
    logic [31:0] slot_d   [N_DUT][8];
    logic [31:0] hold     [N_DUT] = '{32'h0, 32'h0, 32'h0};
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [31:0] base_of(input int d);
        case (d)
            0:       return BASE0;
            1:       return BASE1;
            default: return BASE2;
        endcase
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int stall_of(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic bit addr_bad(input int d, input logic [31:0] a);
        logic [31:0] off;
        if (a < base_of(d)) return 1'b1;
        off = a - base_of(d);
        return (off % 32'd4 != 32'd0) || (off / 32'd4 >= 32'(DEPTH));
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge resetn) begin
        rst_gen <= rst_gen + 1;
    end

    always @(posedge clk) begin : p_model
        int unsigned k;
        int unsigned due;
        int          s;
        int          w;
        bit          acc;
        bit          bad;
        logic [31:0] rd;
        logic [31:0] nw;
        k = ecnt + 1;
        ecnt <= k;
        for (int d = 0; d < N_DUT; d++) begin
            acc = req[d] && resetn && (k >= next_ok[d]);
            last_acc[d] <= acc;
            if (!resetn) begin
                next_ok[d] <= 0;
            end else if (acc) begin
                next_ok[d] <= k + stall_of(d) + 1;
                bad = addr_bad(d, addr[d]);
                rd  = 32'h0;
                if (!bad) begin
                    w = int'((addr[d] - base_of(d)) / 32'd4);
                    if (we[d]) begin
                        nw = mmem[d][w];
                        for (int b = 0; b < 4; b++) begin
                            if (be[d][b]) nw[8*b +: 8] = wdata[d][8*b +: 8];
                        end
                        mmem[d][w] <= nw;
                    end else begin
                        rd = mmem[d][w];
                    end
                end
                due = k + lat_of(d) - 1;
                s   = int'(due % 8);
                slot_set[d][s] <= 1'b1;
                slot_due[d][s] <= due;
                slot_gen[d][s] <= rst_gen;
                slot_e[d][s]   <= bad;
                slot_d[d][s]   <= rd;
            end
        end
    end

    always @(negedge clk) begin : p_check
        int          s;
        bit          v;
        bit          exp_gnt;
        logic [31:0] exp_d;
        s = int'(ecnt % 8);
        for (int d = 0; d < N_DUT; d++) begin
            v = resetn && slot_set[d][s] && (slot_due[d][s] == ecnt) && (slot_gen[d][s] == rst_gen);
            exp_gnt = req[d] && resetn && (ecnt + 1 >= next_ok[d]);
            exp_d = !resetn ? 32'h0 : (v ? slot_d[d][s] : hold[d]);
            chk_val($sformatf("gnt%0d", d),    32'(gnt[d]),    32'(exp_gnt));
            chk_val($sformatf("rvalid%0d", d), 32'(rvalid[d]), 32'(v));
            chk_val($sformatf("err%0d", d),    32'(err[d]),    32'(v && slot_e[d][s]));
            chk_val($sformatf("rdata%0d", d),  rdata[d],       exp_d);
            hold[d] <= exp_d;
        end
    end

    // Called at a falling edge; returns at the falling edge following the accept.
    task automatic do_req(input int d, input bit w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] wd);
        #1;
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (last_acc[d]) return;
        end
        chk_val($sformatf("accept_timeout%0d", d), 32'(last_acc[d]), 32'd1);
    endtask

    task automatic idle(input int n);
        #1;
        for (int d = 0; d < N_DUT; d++) req[d] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_random(input int d, input int n);
        int          kind;
        int          w;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom % 12);
            w    = int'($urandom % DEPTH);
            if (kind < 8)       a = base_of(d) + 32'(4 * w);
            else if (kind < 10) a = base_of(d) + 32'(4 * w) + 32'(1 + $urandom % 3);
            else if (kind < 11) a = base_of(d) + 32'(4 * (DEPTH + int'($urandom % 8)));
            else                a = base_of(d) - 32'(4 * (1 + int'($urandom % 4)));
            if ($urandom % 4 == 0) idle(1 + int'($urandom % 2));
            do_req(d, 1'($urandom), a, 4'($urandom), $urandom);
        end
        idle(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < N_DUT; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; be[d] = 4'h0; wdata[d] = 32'h0;
        end
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        idle(5);
        chk_val("rst_rdata0", rdata[0], 32'h0);

        for (int d = 0; d < N_DUT; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                do_req(d, 1'b1, base_of(d) + 32'(4 * w), 4'hF, $urandom);
            end
        end
        idle(3);

        do_req(0, 1'b1, BASE0 + 32'd8, 4'hF, 32'hDEADBEEF);
        do_req(0, 1'b0, BASE0 + 32'd8, 4'hF, 32'h0);
        idle(2);
        chk_val("rd_deadbeef", rdata[0], 32'hDEADBEEF);

        do_req(0, 1'b1, BASE0 + 32'd12, 4'hF,    32'hAAAAAAAA);
        do_req(0, 1'b1, BASE0 + 32'd12, 4'b0101, 32'h11223344);
        do_req(0, 1'b0, BASE0 + 32'd12, 4'h0,    32'h0);
        idle(2);
        chk_val("partial_wr", rdata[0], 32'hAA22AA44);

        do_req(0, 1'b0, BASE0 + 32'd2, 4'hF, 32'h0);
        idle(2);
        chk_val("misalign_rdata", rdata[0], 32'h0);
        do_req(0, 1'b0, BASE0 + 32'(4 * DEPTH), 4'hF, 32'h0);
        do_req(0, 1'b0, BASE0 - 32'd4, 4'hF, 32'h0);
        do_req(0, 1'b1, BASE0 + 32'(4 * DEPTH), 4'hF, 32'h55555555);
        do_req(0, 1'b1, BASE0 + 32'd13, 4'hF, 32'h55555555);
        do_req(0, 1'b0, BASE0 + 32'd16, 4'hF, 32'h0);
        do_req(0, 1'b0, BASE0 + 32'(4 * (DEPTH - 1)), 4'hF, 32'h0);
        do_req(0, 1'b0, BASE0 + 32'd12, 4'hF, 32'h0);
        idle(2);
        chk_val("bad_wr_no_effect", rdata[0], 32'hAA22AA44);

        // Throttled instance: request held high across four back-to-back reads.
        for (int i = 0; i < 4; i++) do_req(1, 1'b0, BASE1 + 32'(4 * i), 4'hF, 32'h0);
        idle(5);

        do_req(2, 1'b1, BASE2 + 32'd20, 4'hF, 32'hCAFEF00D);
        do_req(2, 1'b1, BASE2 + 32'd24, 4'hF, 32'h12345678);
        idle(4);
        do_req(2, 1'b0, BASE2 + 32'd24, 4'hF, 32'h0);
        do_req(2, 1'b0, BASE2 + 32'd24, 4'hF, 32'h0);
        #1;
        resetn = 1'b0;
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        idle(5);
        chk_val("inflight_dropped", rdata[2], 32'h0);
        do_req(2, 1'b0, BASE2 + 32'd20, 4'hF, 32'h0);
        idle(4);
        chk_val("mem_kept_rst", rdata[2], 32'hCAFEF00D);

        for (int d = 0; d < N_DUT; d++) run_random(d, 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
